// File: rtl/sha256_padder.sv
// SHA-256 message padder: packs big-endian 32-bit words into padded 512-bit blocks.
// Optional macro SHA256_PAD_BYTE_EN: honour in_bytes on the last word; otherwise every last word is full.
module sha256_padder (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  input  logic         in_last,
  input  logic [1:0]   in_bytes,
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic [511:0] blk_data,
  output logic         blk_first,
  output logic         blk_last
);

  typedef enum logic [1:0] {FILL, EMIT, EXTRA} state_t;

  state_t       state_q, state_d;
  logic [511:0] data_q, data_d;
  logic [3:0]   idx_q, idx_d;
  logic [63:0]  len_q, len_d;
  logic         first_q, first_d;
  logic         valid_q, valid_d;
  logic         bfirst_q, bfirst_d;
  logic         blast_q, blast_d;
  logic         extra_q, extra_d;
  logic         extra80_q, extra80_d;

  logic [2:0]   nbytes;
  logic [31:0]  last_word;
  logic [63:0]  len_new;
  logic         fits;
  int unsigned  j;

`ifdef SHA256_PAD_BYTE_EN
  assign nbytes = (in_bytes == 2'd0) ? 3'd4 : {1'b0, in_bytes};
`else
  logic unused_bytes;
  assign unused_bytes = ^in_bytes;
  assign nbytes       = 3'd4;
`endif

  // Partial last word: keep leading bytes and drop the 0x80 marker right after them.
  always_comb begin
    case (nbytes)
      3'd1:    last_word = {in_data[31:24], 24'h80_0000};
      3'd2:    last_word = {in_data[31:16], 16'h8000};
      3'd3:    last_word = {in_data[31:8], 8'h80};
      default: last_word = in_data;
    endcase
  end

  assign len_new = len_q + (in_last ? {58'd0, nbytes, 3'd0} : 64'd32);
  assign j       = 32'(idx_q);
  // The 64-bit length fits only if the 0x80 marker ends up in word 13 or lower.
  assign fits    = (nbytes == 3'd4) ? (idx_q <= 4'd12) : (idx_q <= 4'd13);

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    idx_d     = idx_q;
    len_d     = len_q;
    first_d   = first_q;
    valid_d   = valid_q;
    bfirst_d  = bfirst_q;
    blast_d   = blast_q;
    extra_d   = extra_q;
    extra80_d = extra80_q;
    case (state_q)
      FILL: begin
        if (in_valid) begin
          len_d = len_new;
          if (!in_last) begin
            for (int unsigned k = 0; k < 16; k++) begin
              if (k == j) data_d[511-32*k -: 32] = in_data;
            end
            if (idx_q == 4'd15) begin
              idx_d    = '0;
              state_d  = EMIT;
              valid_d  = 1'b1;
              bfirst_d = first_q;
              blast_d  = 1'b0;
              extra_d  = 1'b0;
              first_d  = 1'b0;
            end else begin
              idx_d = idx_q + 4'd1;
            end
          end else begin
            for (int unsigned k = 0; k < 16; k++) begin
              if (k == j) begin
                data_d[511-32*k -: 32] = last_word;
              end else if (k > j) begin
                data_d[511-32*k -: 32] = ((k == j + 1) && (nbytes == 3'd4)) ? 32'h8000_0000 : 32'h0;
              end
            end
            if (fits) begin
              data_d[63:0] = len_new;
              blast_d      = 1'b1;
              extra_d      = 1'b0;
            end else begin
              blast_d = 1'b0;
              extra_d = 1'b1;
            end
            extra80_d = (idx_q == 4'd15) && (nbytes == 3'd4);
            idx_d     = '0;
            state_d   = EMIT;
            valid_d   = 1'b1;
            bfirst_d  = first_q;
            first_d   = 1'b0;
          end
        end
      end
      EMIT: begin
        if (blk_ready) begin
          if (extra_q) begin
            state_d  = EXTRA;
            data_d   = {(extra80_q ? 32'h8000_0000 : 32'h0), 416'd0, len_q};
            bfirst_d = 1'b0;
            blast_d  = 1'b1;
            extra_d  = 1'b0;
          end else begin
            state_d = FILL;
            valid_d = 1'b0;
            if (blast_q) begin
              len_d   = '0;
              first_d = 1'b1;
            end
            bfirst_d = 1'b0;
            blast_d  = 1'b0;
          end
        end
      end
      EXTRA: begin
        if (blk_ready) begin
          state_d  = FILL;
          valid_d  = 1'b0;
          len_d    = '0;
          first_d  = 1'b1;
          bfirst_d = 1'b0;
          blast_d  = 1'b0;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= FILL;
      data_q    <= '0;
      idx_q     <= '0;
      len_q     <= '0;
      first_q   <= 1'b1;
      valid_q   <= 1'b0;
      bfirst_q  <= 1'b0;
      blast_q   <= 1'b0;
      extra_q   <= 1'b0;
      extra80_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      idx_q     <= idx_d;
      len_q     <= len_d;
      first_q   <= first_d;
      valid_q   <= valid_d;
      bfirst_q  <= bfirst_d;
      blast_q   <= blast_d;
      extra_q   <= extra_d;
      extra80_q <= extra80_d;
    end
  end

  assign in_ready  = (state_q == FILL);
  assign blk_valid = valid_q;
  assign blk_data  = data_q;
  assign blk_first = bfirst_q;
  assign blk_last  = blast_q;

endmodule

// File: tb/tb_sha256_padder.sv
// Bench for sha256_padder: byte-level padding reference model, fixed vector table and hand sequences.
module tb_sha256_padder;
  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [31:0]  in_data = '0;
  logic         in_last = 1'b0;
  logic [1:0]   in_bytes = '0;
  logic         blk_ready = 1'b0;
  logic         in_ready;
  logic         blk_valid;
  logic [511:0] blk_data;
  logic         blk_first;
  logic         blk_last;

  sha256_padder dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .in_bytes(in_bytes),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
    .blk_first(blk_first), .blk_last(blk_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [511:0] data;
    logic         first;
    logic         last;
  } blk_t;

  typedef struct {
    int          n;
    int          nblk;
    logic [31:0] w13, w14, w15;
    logic        last0;
    logic [31:0] lw0, lw15;
  } vec_t;

  blk_t       exp_q[$];
  blk_t       rcv_q[$];
  logic [7:0] wb[$];
  int         msg_n;
  int         n_vec = 0;
  int         n_err = 0;
  vec_t       tbl[6];

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Message bytes padded out to whole words; bytes beyond msg_n are junk the DUT must drop.
  task automatic build_msg(input int n, input logic [7:0] fill, input bit rnd);
    wb.delete();
    msg_n = n;
    for (int i = 0; i < ((n + 3) / 4) * 4; i++) begin
      if (i < n) wb.push_back(rnd ? 8'($urandom) : fill);
      else       wb.push_back(rnd ? 8'($urandom) : 8'h00);
    end
  endtask

  function automatic logic [31:0] word_at(input int i);
    return {wb[4*i], wb[4*i+1], wb[4*i+2], wb[4*i+3]};
  endfunction

  // Textbook SHA-256 padding on a byte list, then cut into 64-byte blocks.
  task automatic build_exp();
    logic [7:0]   p[$];
    logic [63:0]  bits;
    logic [511:0] d;
    int           effn;
    int           nb;
`ifdef SHA256_PAD_BYTE_EN
    effn = msg_n;
`else
    effn = wb.size();
`endif
    exp_q.delete();
    for (int i = 0; i < effn; i++) p.push_back(wb[i]);
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    bits = 64'(effn) * 64'd8;
    for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
    nb = p.size() / 64;
    for (int b = 0; b < nb; b++) begin
      d = '0;
      for (int i = 0; i < 64; i++) d[511-8*i -: 8] = p[64*b+i];
      exp_q.push_back('{d, (b == 0), (b == nb - 1)});
    end
  endtask

  task automatic run_msg();
    int nw;
    int wi;
    int cyc;
    nw  = wb.size() / 4;
    wi  = 0;
    cyc = 0;
    rcv_q.delete();
    build_exp();
    while ((wi < nw || exp_q.size() != 0) && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (blk_valid) begin
        if (exp_q.size() == 0) begin
          chk32("spurious_blk", 32'(blk_valid), 32'd0);
        end else begin
          chk("blk_data", blk_data, exp_q[0].data);
          chk32("blk_flags", {30'd0, blk_first, blk_last}, {30'd0, exp_q[0].first, exp_q[0].last});
        end
      end
      if (wi < nw && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1;
        in_data  = word_at(wi);
        in_last  = (wi == nw - 1);
        in_bytes = 2'(msg_n % 4);
      end else begin
        in_valid = 1'b0;
        in_data  = $urandom;
        in_last  = 1'($urandom);
        in_bytes = 2'($urandom);
      end
      blk_ready = ($urandom_range(0, 2) != 0);
      if (blk_valid && blk_ready && exp_q.size() != 0) begin
        rcv_q.push_back('{blk_data, blk_first, blk_last});
        void'(exp_q.pop_front());
      end
      if (in_valid && in_ready) wi++;
    end
    chk32("msg_pending", 32'(exp_q.size() + (nw - wi)), 32'd0);
    @(negedge clk);
    in_valid  = 1'b0;
    blk_ready = 1'b0;
    chk32("idle_after_msg", {30'd0, blk_valid, in_ready}, 32'd1);
  endtask

  task automatic abc_test(input string name);
    logic [511:0] e;
`ifdef SHA256_PAD_BYTE_EN
    e = {32'h6162_6380, 448'd0, 32'h0000_0018};
`else
    e = {32'h6162_6300, 32'h8000_0000, 416'd0, 32'h0000_0020};
`endif
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'h6162_6300; in_last = 1'b1; in_bytes = 2'd3; blk_ready = 1'b0;
    chk32({name, "_ready"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk32({name, "_valid"}, 32'(blk_valid), 32'd1);
    chk({name, "_data"}, blk_data, e);
    chk32({name, "_flags"}, {30'd0, blk_first, blk_last}, 32'd3);
    blk_ready = 1'b1;
    @(negedge clk);
    blk_ready = 1'b0;
    chk32({name, "_idle"}, {30'd0, blk_valid, in_ready}, 32'd1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] e1;
    logic [31:0]  w;
    blk_t         b0;
    blk_t         bl;

`ifdef SHA256_PAD_BYTE_EN
    tbl[0] = '{55, 1, 32'h6161_6180, 32'h0,         32'h0000_01B8, 1'b1, 32'h6161_6161, 32'h0000_01B8};
    tbl[1] = '{56, 2, 32'h6161_6161, 32'h8000_0000, 32'h0,         1'b0, 32'h0,         32'h0000_01C0};
    tbl[2] = '{64, 2, 32'h6161_6161, 32'h6161_6161, 32'h6161_6161, 1'b0, 32'h8000_0000, 32'h0000_0200};
    tbl[3] = '{5,  1, 32'h0,         32'h0,         32'h0000_0028, 1'b1, 32'h6161_6161, 32'h0000_0028};
    tbl[4] = '{62, 2, 32'h6161_6161, 32'h6161_6161, 32'h6161_8000, 1'b0, 32'h0,         32'h0000_01F0};
    tbl[5] = '{52, 1, 32'h8000_0000, 32'h0,         32'h0000_01A0, 1'b1, 32'h6161_6161, 32'h0000_01A0};
`else
    tbl[0] = '{55, 2, 32'h6161_6100, 32'h8000_0000, 32'h0,         1'b0, 32'h0,         32'h0000_01C0};
    tbl[1] = '{56, 2, 32'h6161_6161, 32'h8000_0000, 32'h0,         1'b0, 32'h0,         32'h0000_01C0};
    tbl[2] = '{64, 2, 32'h6161_6161, 32'h6161_6161, 32'h6161_6161, 1'b0, 32'h8000_0000, 32'h0000_0200};
    tbl[3] = '{5,  1, 32'h0,         32'h0,         32'h0000_0040, 1'b1, 32'h6161_6161, 32'h0000_0040};
    tbl[4] = '{62, 2, 32'h6161_6161, 32'h6161_6161, 32'h6161_0000, 1'b0, 32'h8000_0000, 32'h0000_0200};
    tbl[5] = '{52, 1, 32'h8000_0000, 32'h0,         32'h0000_01A0, 1'b1, 32'h6161_6161, 32'h0000_01A0};
`endif

    repeat (2) @(negedge clk);
    chk32("rst_valid", 32'(blk_valid), 32'd0);
    chk("rst_data", blk_data, '0);
    chk32("rst_flags", {30'd0, blk_first, blk_last}, 32'd0);
    chk32("rst_ready", 32'(in_ready), 32'd1);
    reset_n = 1'b1;

    abc_test("abc");

    for (int t = 0; t < 6; t++) begin
      build_msg(tbl[t].n, 8'h61, 1'b0);
      run_msg();
      chk32("tbl_nblk", 32'(rcv_q.size()), 32'(tbl[t].nblk));
      if (rcv_q.size() > 0) begin
        b0 = rcv_q[0];
        bl = rcv_q[rcv_q.size()-1];
        chk32("tbl_b0_w13", b0.data[95:64], tbl[t].w13);
        chk32("tbl_b0_w14", b0.data[63:32], tbl[t].w14);
        chk32("tbl_b0_w15", b0.data[31:0], tbl[t].w15);
        chk32("tbl_b0_first", 32'(b0.first), 32'd1);
        chk32("tbl_b0_last", 32'(b0.last), 32'(tbl[t].last0));
        chk32("tbl_bl_w0", bl.data[511:480], tbl[t].lw0);
        chk32("tbl_bl_w15", bl.data[31:0], tbl[t].lw15);
        chk32("tbl_bl_flags", {30'd0, bl.first, bl.last}, {30'd0, (tbl[t].nblk == 1), 1'b1});
      end
    end

    // Stall: full block held with blk_ready low for five cycles while in_valid keeps pushing.
    e1 = '0;
    for (int i = 0; i < 16; i++) begin
      w = 32'h1111_1111 * 32'(i + 1);
      e1[511-32*i -: 32] = w;
      @(negedge clk);
      in_valid = 1'b1; in_data = w; in_last = 1'b0; in_bytes = 2'd0;
    end
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'hBAD0_BAD0; in_last = 1'b1; blk_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      chk32("stall_valid", 32'(blk_valid), 32'd1);
      chk32("stall_ready", 32'(in_ready), 32'd0);
      chk("stall_data", blk_data, e1);
      chk32("stall_flags", {30'd0, blk_first, blk_last}, 32'd2);
      if (c < 5) @(negedge clk);
    end
    blk_ready = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    blk_ready = 1'b0;
    chk32("stall_release", {30'd0, blk_valid, in_ready}, 32'd1);
    in_valid = 1'b1; in_data = 32'hDEAD_BEEF; in_last = 1'b1; in_bytes = 2'd0;
    @(negedge clk);
    in_valid = 1'b0;
    chk32("tail_valid", 32'(blk_valid), 32'd1);
    chk("tail_data", blk_data, {32'hDEAD_BEEF, 32'h8000_0000, 416'd0, 32'h0000_0220});
    chk32("tail_flags", {30'd0, blk_first, blk_last}, 32'd1);
    blk_ready = 1'b1;
    @(negedge clk);
    blk_ready = 1'b0;
    chk32("tail_idle", {30'd0, blk_valid, in_ready}, 32'd1);

    // Reset in the middle of a message, then the short message must come out as from cold.
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = $urandom | 32'h1; in_last = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk32("mrst_valid", 32'(blk_valid), 32'd0);
    chk("mrst_data", blk_data, '0);
    chk32("mrst_flags", {30'd0, blk_first, blk_last}, 32'd0);
    chk32("mrst_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    abc_test("abc_after_rst");

    for (int r = 0; r < 30; r++) begin
      build_msg($urandom_range(1, 150), 8'h00, 1'b1);
      run_msg();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
